// File: rtl/pipe_pkg.sv
// Shared types and default sizes for the vector ASIP pipeline registers.
package pipe_pkg;

  localparam int unsigned N_DEF = 32;  // data word width
  localparam int unsigned V_DEF = 20;  // vector lanes

  typedef enum logic [1:0] {
    OP_SCALAR = 2'b00,
    OP_VECTOR = 2'b01,
    OP_MIXED  = 2'b10,
    OP_NONE   = 2'b11
  } op_type_e;

  typedef logic [3:0] regaddr_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic W-bit pipeline flop: async active-low reset to 0, enable, sync clear.
// Clear takes priority over enable so a bubble can be inserted during a stall.
module pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next state: clear beats enable, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_mem_wb_reg.sv
// MEM->WB pipeline register of the vector ASIP.
// Optional macro PIPE_MEM_WB_FLUSH_EN adds flush_i, which loads a bubble
// (all zeros) at the next rising edge regardless of enable_i.
module pipe_mem_wb_reg
  import pipe_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned V = V_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
`ifdef PIPE_MEM_WB_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  enable_i,
  input  logic [N-1:0]          Data_Mem_S_i,
  input  logic [N-1:0]          Data_Result_S_i,
  input  logic                  RegFile_WE_i,
  input  logic                  WBSelect_i,
  input  regaddr_t              A3_i,
  input  op_type_e              OpType_i,
  input  logic [V-1:0][N-1:0]   Data_Mem_V_i,
  input  logic [V-1:0][N-1:0]   Data_Result_V_i,
  output logic [N-1:0]          Data_Mem_S_o,
  output logic [N-1:0]          Data_Result_S_o,
  output logic                  RegFile_WE_o,
  output logic                  WBSelect_o,
  output regaddr_t              A3_o,
  output op_type_e              OpType_o,
  output logic [V-1:0][N-1:0]   Data_Mem_V_o,
  output logic [V-1:0][N-1:0]   Data_Result_V_o
);

  logic       clr;
  logic [1:0] optype_q;

`ifdef PIPE_MEM_WB_FLUSH_EN
  assign clr = flush_i;
`else
  assign clr = 1'b0;
`endif

  pipe_reg #(.W(N)) u_mem_s (
    .clk_i(CLK), .rst_ni(RST), .en_i(enable_i), .clr_i(clr),
    .d_i(Data_Mem_S_i), .q_o(Data_Mem_S_o)
  );

  pipe_reg #(.W(N)) u_res_s (
    .clk_i(CLK), .rst_ni(RST), .en_i(enable_i), .clr_i(clr),
    .d_i(Data_Result_S_i), .q_o(Data_Result_S_o)
  );

  pipe_reg #(.W(1)) u_we (
    .clk_i(CLK), .rst_ni(RST), .en_i(enable_i), .clr_i(clr),
    .d_i(RegFile_WE_i), .q_o(RegFile_WE_o)
  );

  pipe_reg #(.W(1)) u_wbsel (
    .clk_i(CLK), .rst_ni(RST), .en_i(enable_i), .clr_i(clr),
    .d_i(WBSelect_i), .q_o(WBSelect_o)
  );

  pipe_reg #(.W(4)) u_a3 (
    .clk_i(CLK), .rst_ni(RST), .en_i(enable_i), .clr_i(clr),
    .d_i(A3_i), .q_o(A3_o)
  );

  pipe_reg #(.W(2)) u_optype (
    .clk_i(CLK), .rst_ni(RST), .en_i(enable_i), .clr_i(clr),
    .d_i(OpType_i), .q_o(optype_q)
  );

  assign OpType_o = op_type_e'(optype_q);

  // One flop pair per vector lane, lane k in -> lane k out.
  for (genvar k = 0; k < V; k++) begin : g_lane
    pipe_reg #(.W(N)) u_mem_v (
      .clk_i(CLK), .rst_ni(RST), .en_i(enable_i), .clr_i(clr),
      .d_i(Data_Mem_V_i[k]), .q_o(Data_Mem_V_o[k])
    );

    pipe_reg #(.W(N)) u_res_v (
      .clk_i(CLK), .rst_ni(RST), .en_i(enable_i), .clr_i(clr),
      .d_i(Data_Result_V_i[k]), .q_o(Data_Result_V_o[k])
    );
  end

endmodule

// File: tb/tb_pipe_mem_wb_reg.sv
// Self-checking bench for pipe_mem_wb_reg (honours PIPE_MEM_WB_FLUSH_EN).
module tb_pipe_mem_wb_reg;
  import pipe_pkg::*;

  localparam int unsigned N = 32;
  localparam int unsigned V = 20;

  typedef struct packed {
    logic [N-1:0]        mem_s;
    logic [N-1:0]        res_s;
    logic                we;
    logic                wbsel;
    logic [3:0]          a3;
    logic [1:0]          op;
    logic [V-1:0][N-1:0] mem_v;
    logic [V-1:0][N-1:0] res_v;
  } bundle_t;

  logic    CLK = 1'b0;
  logic    RST = 1'b1;
  logic    en = 1'b0;
  logic    flush = 1'b0;
  bundle_t in_b = '0;
  bundle_t exp_b = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [N-1:0]        mem_s_o, res_s_o;
  logic                we_o, wbsel_o;
  regaddr_t            a3_o;
  op_type_e            op_o;
  logic [V-1:0][N-1:0] mem_v_o, res_v_o;

  pipe_mem_wb_reg #(.N(N), .V(V)) dut (
    .CLK             (CLK),
    .RST             (RST),
`ifdef PIPE_MEM_WB_FLUSH_EN
    .flush_i         (flush),
`endif
    .enable_i        (en),
    .Data_Mem_S_i    (in_b.mem_s),
    .Data_Result_S_i (in_b.res_s),
    .RegFile_WE_i    (in_b.we),
    .WBSelect_i      (in_b.wbsel),
    .A3_i            (in_b.a3),
    .OpType_i        (op_type_e'(in_b.op)),
    .Data_Mem_V_i    (in_b.mem_v),
    .Data_Result_V_i (in_b.res_v),
    .Data_Mem_S_o    (mem_s_o),
    .Data_Result_S_o (res_s_o),
    .RegFile_WE_o    (we_o),
    .WBSelect_o      (wbsel_o),
    .A3_o            (a3_o),
    .OpType_o        (op_o),
    .Data_Mem_V_o    (mem_v_o),
    .Data_Result_V_o (res_v_o)
  );

  always #5 CLK = ~CLK;

  function automatic bundle_t dut_out();
    bundle_t b;
    b.mem_s = mem_s_o;
    b.res_s = res_s_o;
    b.we    = we_o;
    b.wbsel = wbsel_o;
    b.a3    = a3_o;
    b.op    = op_o;
    b.mem_v = mem_v_o;
    b.res_v = res_v_o;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.mem_s = $urandom;
    b.res_s = $urandom;
    b.we    = 1'($urandom);
    b.wbsel = 1'($urandom);
    b.a3    = 4'($urandom);
    b.op    = 2'($urandom);
    for (int k = 0; k < int'(V); k++) begin
      b.mem_v[k] = $urandom;
      b.res_v[k] = $urandom;
    end
    return b;
  endfunction

  // Reference: a pipeline register is "output becomes last accepted input".
  task automatic tick();
    @(posedge CLK);
    if (!RST)       exp_b = '0;
    else if (flush) exp_b = '0;
    else if (en)    exp_b = in_b;
    #1;
  endtask

  task automatic test_reset();
    in_b = rand_bundle();
    in_b.mem_s = 32'hDEAD_BEEF;
    en = 1'b1;
    #1 RST = 1'b0;
    exp_b = '0;
    #1;
    checks++;
    if (dut_out() !== exp_b) begin
      errors++;
      $display("FAIL reset_immediate: got %h want %h", dut_out(), exp_b);
    end
    tick();
    checks++;
    if (dut_out() !== exp_b) begin
      errors++;
      $display("FAIL reset_held: got %h want %h", dut_out(), exp_b);
    end
    #2 RST = 1'b1;
  endtask

  task automatic test_capture();
    en = 1'b1;
    in_b = rand_bundle();
    in_b.mem_s = 32'd1;
    tick();
    checks++;
    if (mem_s_o !== 32'd1) begin
      errors++;
      $display("FAIL capture_1: got %0d want 1", mem_s_o);
    end
    in_b.mem_s = 32'd2;
    tick();
    checks++;
    if (mem_s_o !== 32'd2) begin
      errors++;
      $display("FAIL capture_2: got %0d want 2", mem_s_o);
    end
    checks++;
    if (dut_out() !== exp_b) begin
      errors++;
      $display("FAIL capture_bundle: got %h want %h", dut_out(), exp_b);
    end
  endtask

  task automatic test_stall();
    en = 1'b0;
    in_b = rand_bundle();
    in_b.mem_s = 32'd3;
    tick();
    checks++;
    if (mem_s_o !== 32'd2) begin
      errors++;
      $display("FAIL stall_mem_s: got %0d want 2", mem_s_o);
    end
    tick();
    checks++;
    if (dut_out() !== exp_b) begin
      errors++;
      $display("FAIL stall_bundle: got %h want %h", dut_out(), exp_b);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    in_b.mem_s = 32'd4;
    tick();
    checks++;
    if (mem_s_o !== 32'd4) begin
      errors++;
      $display("FAIL pre_async_capture: got %0d want 4", mem_s_o);
    end
    #2 RST = 1'b0;
    exp_b = '0;
    #1;
    checks++;
    if (dut_out() !== exp_b) begin
      errors++;
      $display("FAIL async_reset_midcycle: got %h want %h", dut_out(), exp_b);
    end
    #3 RST = 1'b1;
    in_b = rand_bundle();
    tick();
    checks++;
    if (dut_out() !== exp_b) begin
      errors++;
      $display("FAIL first_capture_after_reset: got %h want %h", dut_out(), exp_b);
    end
  endtask

  task automatic test_all_fields();
    en = 1'b1;
    in_b.mem_s = 32'h1234_5678;
    in_b.res_s = 32'h9ABC_DEF0;
    in_b.a3    = 4'hF;
    in_b.op    = 2'b01;
    in_b.we    = 1'b1;
    in_b.wbsel = 1'b1;
    for (int k = 0; k < int'(V); k++) begin
      in_b.mem_v[k] = 32'(k + 1);
      in_b.res_v[k] = 32'(100 + k);
    end
    tick();
    checks++;
    if (a3_o !== 4'hF || op_o !== OP_VECTOR || we_o !== 1'b1 || wbsel_o !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_fields: got a3=%h op=%b we=%b sel=%b want F 01 1 1",
               a3_o, op_o, we_o, wbsel_o);
    end
    for (int k = 0; k < int'(V); k++) begin
      checks++;
      if (mem_v_o[k] !== 32'(k + 1) || res_v_o[k] !== 32'(100 + k)) begin
        errors++;
        $display("FAIL lane_%0d: got mem=%0d res=%0d want %0d %0d",
                 k, mem_v_o[k], res_v_o[k], k + 1, 100 + k);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
`ifdef PIPE_MEM_WB_FLUSH_EN
      flush = 1'($urandom_range(0, 7) == 0);
`endif
      in_b = rand_bundle();
      tick();
      checks++;
      if (dut_out() !== exp_b) begin
        errors++;
        $display("FAIL random_%0d: got %h want %h", i, dut_out(), exp_b);
      end
    end
    flush = 1'b0;
  endtask

`ifdef PIPE_MEM_WB_FLUSH_EN
  task automatic test_flush();
    en = 1'b1;
    in_b = rand_bundle();
    in_b.we = 1'b1;
    tick();
    en = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (dut_out() !== '0) begin
      errors++;
      $display("FAIL flush_over_stall: got %h want 0", dut_out());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_capture();
    test_stall();
    test_async_reset();
    test_all_fields();
    test_random();
`ifdef PIPE_MEM_WB_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
